// File: rtl/fifo_rd_packer.sv
// Read-side consumer for the async FIFO: packs RATIO consecutive entries into one
// wide word and presents it on a valid/ready stream through a 2-entry output queue.
//
// state          | meaning
// ST_FILL        | popping entries into the accumulator; flush handled immediately if a slot is free
// ST_FLUSH_PEND  | flush requested but output queue full; popping held off until a slot frees
module fifo_rd_packer #(
    parameter int DATASIZE = 8,
    parameter int RATIO    = 4
) (
    input  logic                      rclk,
    input  logic                      rrst_n,
    input  logic [DATASIZE-1:0]       rdata,
    input  logic                      rempty,
    output logic                      rinc,
    input  logic                      flush,
    output logic [DATASIZE*RATIO-1:0] m_data,
    output logic [RATIO-1:0]          m_keep,
    output logic                      m_last,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      busy
);

    localparam int WW = DATASIZE * RATIO;
    localparam int CW = $clog2(RATIO);
    localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

    typedef enum logic {
        ST_FILL       = 1'b0,
        ST_FLUSH_PEND = 1'b1
    } state_t;

    typedef struct packed {
        logic             last;
        logic [RATIO-1:0] keep;
        logic [WW-1:0]    data;
    } q_entry_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   lane_cnt, lane_cnt_nxt;
    logic [WW-1:0]   acc, acc_nxt, acc_ins;
    logic [RATIO-1:0] partial_keep;

    q_entry_t        q0, q1, q0_nxt, q1_nxt, push_entry;
    logic [1:0]      qcount, qcount_nxt;
    logic [1:0]      wr_idx;

    logic            flush_pend;
    logic            flush_req;
    logic            slot_free;
    logic            do_flush;
    logic            q_pop;
    logic            push;
    logic            pop_last;

    assign flush_pend = (state == ST_FLUSH_PEND);
    assign q_pop      = m_valid && m_ready;
    // qcount==2 implies m_valid, so m_ready alone means a transfer frees a slot
    assign slot_free  = (qcount != 2'd2) || m_ready;
    assign flush_req  = flush_pend || (flush && (lane_cnt != '0));
    assign do_flush   = flush_req && slot_free;

    assign rinc = rrst_n && !rempty && !flush && !flush_pend &&
                  ((lane_cnt != LAST_LANE) || slot_free);
    assign pop_last = rinc && (lane_cnt == LAST_LANE);

    assign partial_keep = (RATIO'(1) << lane_cnt) - RATIO'(1);

    always_comb begin
        acc_ins = acc;
        for (int i = 0; i < RATIO; i++) begin
            if (lane_cnt == CW'(i)) begin
                acc_ins[i*DATASIZE +: DATASIZE] = rdata;
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        lane_cnt_nxt    = lane_cnt;
        acc_nxt         = acc;
        push            = 1'b0;
        push_entry.data = acc_ins;
        push_entry.keep = '1;
        push_entry.last = 1'b0;
        case (state)
            ST_FILL: begin
                if (flush_req) begin
                    if (do_flush) begin
                        push            = 1'b1;
                        push_entry.data = acc;
                        push_entry.keep = partial_keep;
                        push_entry.last = 1'b1;
                        lane_cnt_nxt    = '0;
                        acc_nxt         = '0;
                    end else begin
                        state_nxt = ST_FLUSH_PEND;
                    end
                end else if (rinc) begin
                    if (pop_last) begin
                        push         = 1'b1;
                        lane_cnt_nxt = '0;
                        acc_nxt      = '0;
                    end else begin
                        acc_nxt      = acc_ins;
                        lane_cnt_nxt = lane_cnt + CW'(1);
                    end
                end
            end
            ST_FLUSH_PEND: begin
                if (slot_free) begin
                    push            = 1'b1;
                    push_entry.data = acc;
                    push_entry.keep = partial_keep;
                    push_entry.last = 1'b1;
                    lane_cnt_nxt    = '0;
                    acc_nxt         = '0;
                    state_nxt       = ST_FILL;
                end
            end
            default: state_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state    <= ST_FILL;
            lane_cnt <= '0;
            acc      <= '0;
        end else begin
            state    <= state_nxt;
            lane_cnt <= lane_cnt_nxt;
            acc      <= acc_nxt;
        end
    end

    // Output queue: q0 is the head; a push lands behind whatever survives the pop.
    always_comb begin
        q0_nxt     = q0;
        q1_nxt     = q1;
        qcount_nxt = qcount;
        wr_idx     = qcount - {1'b0, q_pop};
        if (q_pop) begin
            q0_nxt = q1;
        end
        if (push) begin
            if (wr_idx == 2'd0) begin
                q0_nxt = push_entry;
            end else begin
                q1_nxt = push_entry;
            end
        end
        case ({push, q_pop})
            2'b10:   qcount_nxt = qcount + 2'd1;
            2'b01:   qcount_nxt = qcount - 2'd1;
            default: qcount_nxt = qcount;
        endcase
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            q0     <= '0;
            q1     <= '0;
            qcount <= 2'd0;
        end else begin
            q0     <= q0_nxt;
            q1     <= q1_nxt;
            qcount <= qcount_nxt;
        end
    end

    assign m_valid = (qcount != 2'd0);
    assign m_data  = q0.data;
    assign m_keep  = q0.keep;
    assign m_last  = q0.last;
    assign busy    = (lane_cnt != '0) || flush_pend;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer (DATASIZE=8, RATIO=4) with a queue model of the FIFO.
module tb_fifo_rd_packer;

    logic        rclk = 1'b0;
    logic        rrst_n;
    logic [7:0]  rdata;
    logic        rempty;
    logic        rinc;
    logic        flush;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last;
    logic        m_valid;
    logic        m_ready;
    logic        busy;

    logic [7:0]  fq[$];
    logic [63:0] rx[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          rinc_cnt = 0;
    int          vld_cnt  = 0;
    logic        last_rinc = 1'b0;

    always #5 rclk = ~rclk;

    fifo_rd_packer #(.DATASIZE(8), .RATIO(4)) dut (
        .rclk    (rclk),
        .rrst_n  (rrst_n),
        .rdata   (rdata),
        .rempty  (rempty),
        .rinc    (rinc),
        .flush   (flush),
        .m_data  (m_data),
        .m_keep  (m_keep),
        .m_last  (m_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .busy    (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic last, input logic [3:0] keep, input logic [31:0] data);
        return {27'd0, last, keep, data};
    endfunction

    function automatic logic [63:0] rx_pop();
        if (rx.size() == 0) return '1;
        return rx.pop_front();
    endfunction

    task automatic drive_fifo();
        rempty = (fq.size() == 0);
        rdata  = (fq.size() != 0) ? fq[0] : 8'h00;
    endtask

    task automatic push_e(input logic [7:0] v);
        fq.push_back(v);
        drive_fifo();
    endtask

    // Sample between edges, then advance one clock and apply the FIFO pop.
    task automatic cycle();
        #2;
        last_rinc = rinc;
        if (rinc) rinc_cnt++;
        if (m_valid) vld_cnt++;
        if (m_valid && m_ready) rx.push_back(mk(m_last, m_keep, m_data));
        @(posedge rclk);
        #1;
        if (last_rinc && fq.size() != 0) fq.delete(0);
        drive_fifo();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rrst_n  = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        drive_fifo();
        #2;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data",  m_data, 0);
        check("rst_m_keep",  m_keep, 0);
        check("rst_m_last",  m_last, 0);
        check("rst_busy",    busy, 0);
        push_e(8'h11); push_e(8'h22); push_e(8'h33); push_e(8'h44);
        #1;
        check("rst_rinc", rinc, 0);

        // full word
        @(posedge rclk); #1;
        rrst_n = 1'b1; m_ready = 1'b1; rinc_cnt = 0; vld_cnt = 0;
        repeat (4) cycle();
        check("t1_rinc_cnt", rinc_cnt, 4);
        check("t1_valid",    m_valid, 1);
        check("t1_word",     mk(m_last, m_keep, m_data), mk(0, 4'hF, 32'h44332211));
        check("t1_busy",     busy, 0);
        repeat (3) cycle();
        check("t1_valid_off", m_valid, 0);
        check("t1_vld_cnt",   vld_cnt, 1);
        check("t1_rx",        rx_pop(), mk(0, 4'hF, 32'h44332211));

        // flush of a 2-lane and a 1-lane partial word
        push_e(8'hAA); push_e(8'hBB);
        repeat (2) cycle();
        check("t2_busy_acc", busy, 1);
        push_e(8'hCC);
        flush = 1'b1; cycle(); flush = 1'b0;
        check("t2_no_pop",  last_rinc, 0);
        check("t2_word",    mk(m_last, m_keep, m_data), mk(1, 4'h3, 32'h0000BBAA));
        check("t2_busy",    busy, 0);
        cycle();
        check("t2_pop_cc",  last_rinc, 1);
        check("t2_busy_cc", busy, 1);
        flush = 1'b1; cycle(); flush = 1'b0;
        check("t2_word1",   mk(m_last, m_keep, m_data), mk(1, 4'h1, 32'h000000CC));
        cycle();
        check("t2_rx0", rx_pop(), mk(1, 4'h3, 32'h0000BBAA));
        check("t2_rx1", rx_pop(), mk(1, 4'h1, 32'h000000CC));

        // backpressure: queue fills, rinc stalls at lane 3
        m_ready = 1'b0; rinc_cnt = 0;
        for (int i = 1; i <= 12; i++) push_e(8'(i));
        repeat (4) cycle();
        check("t3_head", mk(m_last, m_keep, m_data), mk(0, 4'hF, 32'h04030201));
        repeat (11) cycle();
        check("t3_rinc_cnt", rinc_cnt, 11);
        check("t3_fifo_left", fq.size(), 1);
        check("t3_stall",     last_rinc, 0);
        check("t3_hold",      m_data, 32'h04030201);
        check("t3_busy",      busy, 1);
        m_ready = 1'b1;
        repeat (3) cycle();
        check("t3_rx0", rx_pop(), mk(0, 4'hF, 32'h04030201));
        check("t3_rx1", rx_pop(), mk(0, 4'hF, 32'h08070605));
        check("t3_rx2", rx_pop(), mk(0, 4'hF, 32'h0C0B0A09));
        check("t3_empty", m_valid, 0);

        // flush while queue full -> pending
        m_ready = 1'b0; rinc_cnt = 0;
        for (int i = 8'h21; i <= 8'h2B; i++) push_e(8'(i));
        repeat (10) cycle();
        check("t4_rinc_cnt", rinc_cnt, 10);
        flush = 1'b1; cycle(); flush = 1'b0;
        check("t4_flush_nopop", last_rinc, 0);
        cycle();
        check("t4_pend_rinc", last_rinc, 0);
        check("t4_pend_busy", busy, 1);
        check("t4_pend_fifo", fq.size(), 1);
        m_ready = 1'b1;
        cycle();
        check("t4_release_rinc", last_rinc, 0);
        check("t4_release_busy", busy, 0);
        check("t4_head_w2", m_data, 32'h28272625);
        cycle();
        check("t4_resume", last_rinc, 1);
        check("t4_head_part", mk(m_last, m_keep, m_data), mk(1, 4'h3, 32'h00002A29));
        cycle();
        flush = 1'b1; cycle(); flush = 1'b0;
        cycle();
        check("t4_rx0", rx_pop(), mk(0, 4'hF, 32'h24232221));
        check("t4_rx1", rx_pop(), mk(0, 4'hF, 32'h28272625));
        check("t4_rx2", rx_pop(), mk(1, 4'h3, 32'h00002A29));
        check("t4_rx3", rx_pop(), mk(1, 4'h1, 32'h0000002B));

        // flush with nothing accumulated and FIFO empty
        rinc_cnt = 0; vld_cnt = 0;
        flush = 1'b1; cycle(); flush = 1'b0;
        repeat (5) cycle();
        check("t5_rinc_cnt", rinc_cnt, 0);
        check("t5_vld_cnt",  vld_cnt, 0);
        check("t5_busy",     busy, 0);
        check("t5_rx_none",  rx.size(), 0);

        // reset mid-word with a word queued
        m_ready = 1'b0;
        for (int i = 8'h51; i <= 8'h57; i++) push_e(8'(i));
        repeat (7) cycle();
        check("t6_pre_valid", m_valid, 1);
        check("t6_pre_busy",  busy, 1);
        rrst_n = 1'b0;
        #1;
        check("t6_rst_valid", m_valid, 0);
        check("t6_rst_word",  mk(m_last, m_keep, m_data), 64'd0);
        check("t6_rst_busy",  busy, 0);
        push_e(8'h61); push_e(8'h62); push_e(8'h63); push_e(8'h64);
        #1;
        check("t6_rst_rinc", rinc, 0);
        rrst_n = 1'b1; m_ready = 1'b1; rx.delete();
        repeat (4) cycle();
        check("t6_clean", mk(m_last, m_keep, m_data), mk(0, 4'hF, 32'h64636261));
        check("t6_valid", m_valid, 1);
        cycle();
        check("t6_rx", rx_pop(), mk(0, 4'hF, 32'h64636261));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
- Single-clock consumer for the read side of the team's async FIFO.
- Pops DATASIZE-wide entries through the FIFO's rdata/rempty/rinc interface and packs RATIO consecutive entries into one wide word.
- Presents each wide word on a valid/ready output stream through a 2-entry output queue.
- A flush input emits a partial word with lane-keep flags, for packet ends.

Parameters:
- DATASIZE, 8, width of one FIFO entry (one lane).
- RATIO, 4, lanes per output word (2..16).

Ports:
- rclk  input  1  read-domain clock; all state updates on its rising edge.
- rrst_n  input  1  asynchronous active-low reset.
- rdata  input  DATASIZE  FIFO head entry; valid whenever rempty=0 (first-word-fall-through).
- rempty  input  1  FIFO empty flag (registered in rclk domain).
- rinc  output  1  pop request to the FIFO; an entry is consumed at each rclk edge with rinc=1.
- flush  input  1  single-cycle request to emit the current partial word.
- m_data  output  DATASIZE*RATIO  packed output word; lane i at bits [i*DATASIZE +: DATASIZE].
- m_keep  output  RATIO  per-lane valid flags for m_data.
- m_last  output  1  1 on words produced by flush.
- m_valid  output  1  output word available.
- m_ready  input  1  downstream accepts; transfer on the edge where m_valid && m_ready.
- busy  output  1  accumulator holds at least one lane, or a flush is pending.

Behaviour:
- Reset (rrst_n low, asynchronous):
  - lane count = 0; flush_pend = 0; queue count = 0.
  - m_valid = 0, m_data = 0, m_keep = 0, m_last = 0, busy = 0.
  - rinc = 0 while rrst_n is low.
  - Reset mid-word discards accumulated lanes without emitting them.
- Lane order: the first popped entry goes to lane 0 (LSBs); lane index = accumulator count at the time of the pop.
- Queue state: 2-entry output queue, qcount 0..2. "Slot free" means qcount<2, or qcount==2 with an output transfer in the same cycle.
- rinc (combinational):
  - Asserted only when rempty=0, flush=0 and flush_pend=0.
  - When lane count = RATIO-1, additionally requires a free slot.
  - Never asserted while rempty=1.
- Pop with lane count < RATIO-1: lane captured, count+1.
- Pop with lane count = RATIO-1:
  - The full word (including this lane) is written to the queue at the same edge, with m_keep all ones and m_last=0.
  - Count returns to 0.
  - Latency: the edge capturing the last lane makes m_valid=1 on the following cycle when the queue was empty.
- Flush with count = 0: no-op; no word emitted; flush_pend stays 0.
- Flush with count > 0:
  - No pop occurs in that cycle.
  - If a slot is free, the partial word is written at that edge: lanes 0..count-1 carry data, unused lanes are 0, m_keep has bits [count-1:0] set, m_last=1. Count then returns to 0.
  - Otherwise flush_pend=1 and rinc is held low until a slot frees. The partial word is then written at that edge and flush_pend clears.
  - A flush asserted while flush_pend=1 is absorbed.
- Output queue:
  - FIFO order.
  - Push and pop in the same cycle are allowed at any qcount, including qcount=2 with a pop.
  - While m_valid && !m_ready, m_data/m_keep/m_last hold stable.
  - m_valid = (qcount>0).
- Throughput:
  - One lane per cycle when the FIFO is non-empty.
  - One output word per RATIO cycles, with no bubbles when m_ready is held high.
- busy = (count>0) || flush_pend.

Test Plan:
- RATIO=4, DATASIZE=8; FIFO supplies 0x11,0x22,0x33,0x44, m_ready=1 -> rinc high 4 consecutive cycles; one cycle after the 4th pop: m_data=0x44332211, m_keep=4'b1111, m_last=0, m_valid high for exactly 1 cycle.
- Pop 0xAA,0xBB, then flush pulse, m_ready=1 -> no pop in the flush cycle; m_data=0x0000BBAA, m_keep=4'b0011, m_last=1; busy drops to 0.
- m_ready=0, supply 12 entries 0x01..0x0C -> two words queued (0x04030201, 0x08070605); rinc stalls with count=3 after 0x0B; m_ready=1 -> words emerge in order and 0x0C0B0A09 follows; m_data stable during the stall.
- Queue full (m_ready=0), count=2, flush -> flush_pend=1, rinc=0, busy=1; raise m_ready -> partial word emitted with m_keep=4'b0011, m_last=1; popping resumes.
- Flush with count=0, and rempty=1 throughout -> rinc never asserted; no m_valid.
- Assert rrst_n=0 mid-word (count=3) -> all outputs 0 immediately; after release the next 4 entries form a clean word with no stale lanes.
